// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared defaults, register word type and address-width helper
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  typedef logic [XLEN_DEF-1:0] word_t;

  // Never returns 0 so a 1-register corner case still gets a legal port width.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_mp_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register pending-write bits with set-priority and hazard lookup
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = NRD_DEF,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRD-1:0][AW-1:0] raddr_i,
  input  logic [AW-1:0]          waddr_i,
  input  logic                   reg_wr_c,
  input  logic                   busy_set_i,
  input  logic [AW-1:0]          busy_addr_i,
  output logic [NRD-1:0]         hazard_o,
  output logic [NREGS-1:0]       busy_vec_o
);

  logic [NREGS-1:0] busy_next;

  // Clear first, then set, so a new producer on the same edge supersedes the write.
  always_comb begin
    busy_next = busy_vec_o;
    if (reg_wr_c)
      busy_next[waddr_i] = 1'b0;
    if (busy_set_i)
      busy_next[busy_addr_i] = 1'b1;
    if (ZERO_REG)
      busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_vec_o <= '0;
    else
      busy_vec_o <= busy_next;
  end

  always_comb begin
    hazard_o = '0;
    for (int p = 0; p < NRD; p++)
      hazard_o[p] = busy_vec_o[raddr_i[p]] & ~(reg_wr_c && (waddr_i == raddr_i[p]));
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module      : reg_file_mp
// Description : Multi-read-port register file, registered reads, write-first bypass
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = NRD_DEF,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD-1:0][AW-1:0]   raddr_i,
  input  logic [NRD-1:0]           rd_en_i,
  output logic [NRD-1:0][XLEN-1:0] rdata_o,
  input  logic [AW-1:0]            waddr_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic                     reg_wr_c,
  input  logic                     busy_set_i,
  input  logic [AW-1:0]            busy_addr_i,
  output logic [NRD-1:0]           hazard_o,
  output logic [NREGS-1:0]         busy_vec_o
);

  logic [XLEN-1:0]          regs [NREGS];
  logic                     we;
  logic [NRD-1:0][XLEN-1:0] rd_next;

  assign we = reg_wr_c && !(ZERO_REG && (waddr_i == '0));

  // Zero-register check comes first so a dropped write to x0 is never bypassed.
  always_comb begin
    rd_next = '0;
    for (int p = 0; p < NRD; p++) begin
      if (ZERO_REG && (raddr_i[p] == '0))
        rd_next[p] = '0;
      else if (reg_wr_c && (waddr_i == raddr_i[p]))
        rd_next[p] = wdata_i;
      else
        rd_next[p] = regs[raddr_i[p]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      rdata_o <= '0;
    end else begin
      if (we)
        regs[waddr_i] <= wdata_i;
      for (int p = 0; p < NRD; p++)
        if (rd_en_i[p])
          rdata_o[p] <= rd_next[p];
    end
  end

  reg_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .raddr_i     (raddr_i),
    .waddr_i     (waddr_i),
    .reg_wr_c    (reg_wr_c),
    .busy_set_i  (busy_set_i),
    .busy_addr_i (busy_addr_i),
    .hazard_o    (hazard_o),
    .busy_vec_o  (busy_vec_o)
  );

endmodule

`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the core's decode/execute boundary, with registered reads, same-cycle write-to-read bypass, a hardwired zero register, asynchronous clear, and a per-register pending-write scoreboard. It replaces the fixed 2-read/32x32 file. Decode uses it to fetch operands and to detect load-use and CSR-read hazards without a separate hazard table.

## Interface
- XLEN, 32, data width in bits (≥ 8)
- NREGS, 32, number of architectural registers (power of two, ≥ 2); AW = $clog2(NREGS)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy; 0: register 0 is ordinary
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears every register, every read output and every busy bit
- raddr_i  in  NRD x AW  read address per port
- rd_en_i  in  NRD  read enable per port; 0 holds that port's output
- rdata_o  out  NRD x XLEN  registered read data per port
- waddr_i  in  AW  write address
- wdata_i  in  XLEN  write data
- reg_wr_c  in  1  write strobe
- busy_set_i  in  1  mark busy_addr_i as pending (long-latency producer issued)
- busy_addr_i  in  AW  register to mark pending
- hazard_o  out  NRD  combinational: busy[raddr_i[p]] and not cleared by this cycle's write
- busy_vec_o  out  NREGS  registered busy bits

## Operation
- Reset: all registers = 0, rdata_o = 0, busy_vec_o = 0, hazard_o = 0.
- Write: on a rising edge with reg_wr_c = 1, register[waddr_i] <= wdata_i. With ZERO_REG = 1 and waddr_i = 0 the write is dropped.
- Read, per port p: on a rising edge with rd_en_i[p] = 1, rdata_o[p] <= value of register[raddr_i[p]]. If reg_wr_c = 1 and waddr_i == raddr_i[p] in that cycle, the new wdata_i is captured (write-first bypass). Register 0 with ZERO_REG = 1 always returns 0. With rd_en_i[p] = 0 the output holds.
- Scoreboard: busy[busy_addr_i] is set on an edge with busy_set_i = 1. busy[waddr_i] is cleared on an edge with reg_wr_c = 1.
- Simultaneous set and clear of the same address: set wins, because the new producer supersedes.
- Set to register 0 with ZERO_REG = 1 is ignored.
- Set of an already-busy register: remains busy. There is no counting; one write clears it.
- hazard_o[p] = busy[raddr_i[p]] & ~(reg_wr_c & waddr_i == raddr_i[p]). A write landing this cycle resolves the hazard via the bypass.
- All NRD ports may read the same address in the same cycle; each gets identical data.

## Timing
- Read latency: 1 cycle from address/enable to rdata_o.
- Write visible to a read issued in the same cycle (bypass), so effective write-to-read latency is 0.
- busy_vec_o reflects a set/clear 1 cycle after the strobe edge. hazard_o is combinational from the current busy state and inputs.
- Reset asserted mid-operation clears state immediately, without waiting for clk. The first edge after deassertion behaves as a normal cycle.
- No back-pressure; every strobe is accepted every cycle.

## Structure
- Shared package reg_file_pkg: default XLEN/NREGS/NRD constants, typedef for the register word, and an addr-width helper function. Other pipeline blocks import the same types.
- Sub-module reg_scoreboard: NREGS busy bits, set/clear logic with set-priority, hazard_o lookup, and ZERO_REG masking.
- reg_file_mp holds the storage array, bypass muxes and read registers.
- Single always_ff for storage/read registers on clk/reset. No negedge logic.

## Test plan
- Reset then read all NREGS on every port: every rdata_o = 0 and busy_vec_o = 0. Assert reset mid-stream after writing x5 = 0xDEADBEEF: rdata_o goes to 0 asynchronously and x5 then reads 0.
- Write x7 = 0x12345678 and read x7 on port 0 in the same cycle: the next cycle rdata_o[0] = 0x12345678. Port 1 reading x7 in the same cycle also returns 0x12345678.
- With ZERO_REG = 1, write x0 = 0xFFFFFFFF then read x0: returns 0. busy_set_i on x0: busy_vec_o[0] stays 0.
- Write x3 = 0xA5A5A5A5, then read x3 with rd_en_i[0] = 0: rdata_o[0] keeps its previous value. Raise rd_en_i: the next cycle rdata_o[0] = 0xA5A5A5A5.
- busy_set_i on x9, then read x9: hazard_o[0] = 1 and busy_vec_o[9] = 1. Write x9 = 0x55: in that cycle hazard_o[0] = 0, and the next cycle busy_vec_o[9] = 0 and rdata_o = 0x55.
- Same edge busy_set_i on x4 and reg_wr_c to x4 = 0x77: busy_vec_o[4] = 1 afterwards and x4 reads 0x77. Repeat with NRD = 4, NREGS = 16, XLEN = 64, with all four ports reading distinct registers.
